mem_tp_fifo_ctrl: RTL and testbench
===================================

Name: mem_tp_fifo_ctrl

Overview:
- First-word-fall-through FIFO controller that drives the two-port bit-write-enable memory wrapper directly.
  - Port A of the memory is the write port; port B is the read port.
- Converts valid/ready push and pop streams into memory accesses.
- Hides the 1-cycle memory read latency with a 2-entry output buffer, so pop throughput is one word per cycle.
- Used for deep packet and data buffering in front of network and DMA logic.

Parameters:
- DATAWIDTH, 128: word width; must equal the memory's MEM_DATAWIDTH.
- ADDRWIDTH, 14: memory address width; memory depth MEM_DEPTH = 2^ADDRWIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all contents.
- push_valid  in  1  write request.
- push_ready  out  1  controller can accept a word.
- push_data  in  DATAWIDTH  word to enqueue.
- pop_valid  out  1  pop_data holds the head word.
- pop_ready  in  1  consumer takes the head word.
- pop_data  out  DATAWIDTH  head word.
- fill_level  out  ADDRWIDTH+2  total words held.
- mem_ena  out  1  memory port A enable.
- mem_wea  out  DATAWIDTH  bit write enable; all ones when mem_ena=1, else 0.
- mem_addra  out  ADDRWIDTH  write address.
- mem_dina  out  DATAWIDTH  write data (= push_data).
- mem_enb  out  1  memory port B read enable.
- mem_addrb  out  ADDRWIDTH  read address.
- mem_doutb  in  DATAWIDTH  read data, valid the cycle after mem_enb.

Behaviour:
- Reset (async): wr_ptr=0, rd_ptr=0, mem_count=0, rd_inflight=0, out_count=0.
  - Outputs: push_ready=1 once reset deasserts; pop_valid=0; fill_level=0; mem_ena=0; mem_enb=0.
  - pop_data is don't-care while pop_valid=0.
- Push:
  - push_ready = (mem_count != MEM_DEPTH) && !flush.
  - push_fire = push_valid && push_ready.
  - On push_fire: mem_ena=1, mem_addra=wr_ptr, mem_dina=push_data, all in the same cycle (combinational).
  - wr_ptr increments modulo MEM_DEPTH.
- Read issue:
  - mem_enb = !flush && mem_count != 0 && (out_count + rd_inflight - pop_fire) < 2.
  - mem_addrb = rd_ptr; rd_ptr increments modulo MEM_DEPTH; rd_inflight_next = mem_enb.
  - mem_count is registered: a word written in cycle t is readable from t+1 at the earliest. No same-address read/write collision is possible.
- Capture: when rd_inflight=1, mem_doutb is appended to the output buffer at the end of that cycle.
- Output buffer:
  - 2-entry in-order buffer; pop_valid = (out_count != 0); pop_data = head entry.
  - pop_fire = pop_valid && pop_ready. Pop and capture in the same cycle is legal; out_count is unchanged.
- mem_count: +1 on push_fire, -1 on mem_enb; both in the same cycle leaves it unchanged.
- fill_level = mem_count + rd_inflight + out_count; maximum value is MEM_DEPTH+2.
- Latency: push into an empty FIFO in cycle t -> mem_enb at t+1 -> capture at t+2 -> pop_valid=1 at t+3.
- Throughput: sustained 1 push and 1 pop per cycle.
- Full: push_ready=0 when mem_count=MEM_DEPTH, even if the output buffer has space (capacity is MEM_DEPTH+2 only through prefetch).
- Empty: pop_valid=0; mem_enb=0 when mem_count=0.
- Pointer wrap: natural modulo 2^ADDRWIDTH; no special case.
- Flush (synchronous, highest priority):
  - In the flush cycle: push_ready=0, mem_ena=0, mem_enb=0.
  - Next cycle: all pointers and counts are 0 and pop_valid=0.
  - A read in flight during the flush cycle is discarded, not captured.
  - pop_fire during flush is ignored; contents are dropped.
- Reset mid-operation: immediate return to reset state; memory contents are don't-care.

Test Plan:
All scenarios use ADDRWIDTH=2 (depth 4, capacity 6) and DATAWIDTH=8.
- Single word: push 0xA5 at cycle 0, pop_ready=1 -> mem_ena=1, mem_addra=0 at cycle 0; mem_enb=1, mem_addrb=0 at cycle 1; pop_valid=1, pop_data=0xA5 at cycle 3; fill_level returns to 0 at cycle 4.
- Fill: push 0x01..0x08 continuously, pop_ready=0 -> 6 words accepted; push_ready=0 from then on; fill_level=6; then pop all -> order 0x01..0x06, fill_level=0.
- Streaming: push and pop every cycle for 20 words (0x00..0x13) -> no bubbles after the initial 3-cycle latency, mem_addra and mem_addrb wrap 3->0, output in order.
- Backpressure toggle: pop_ready alternating 1/0 during streaming -> no loss or duplication; mem_enb never issues while out_count + rd_inflight would exceed 2.
- Flush with a read in flight: 3 words stored, flush asserted in a cycle with mem_enb=1 -> next cycle pop_valid=0, fill_level=0; the late mem_doutb is not captured; a subsequent push of 0x77 pops as 0x77.
- Async reset mid-stream: reset asserted between edges -> pop_valid, mem_ena, mem_enb drop to 0 immediately; fill_level=0; push_ready=1 after deassert.

Source files
------------

// File: rtl/mem_tp_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a two-port memory (A = write, B = read).
// A 2-entry output buffer hides the 1-cycle read latency so pops can run at one word per cycle.
module mem_tp_fifo_ctrl #(
    parameter int DATAWIDTH = 128,
    parameter int ADDRWIDTH = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [DATAWIDTH-1:0]   push_data,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [DATAWIDTH-1:0]   pop_data,
    output logic [ADDRWIDTH+1:0]   fill_level,
    output logic                   mem_ena,
    output logic [DATAWIDTH-1:0]   mem_wea,
    output logic [ADDRWIDTH-1:0]   mem_addra,
    output logic [DATAWIDTH-1:0]   mem_dina,
    output logic                   mem_enb,
    output logic [ADDRWIDTH-1:0]   mem_addrb,
    input  logic [DATAWIDTH-1:0]   mem_doutb
);

    localparam logic [ADDRWIDTH:0] MEM_FULL = {1'b1, {ADDRWIDTH{1'b0}}};

    logic [ADDRWIDTH-1:0] wr_ptr_r;
    logic [ADDRWIDTH-1:0] rd_ptr_r;
    logic [ADDRWIDTH:0]   mem_count_r;
    logic                 rd_inflight_r;
    logic [1:0]           out_count_r;
    logic [DATAWIDTH-1:0] buf0_r;
    logic [DATAWIDTH-1:0] buf1_r;

    logic                 push_ready_s;
    logic                 push_fire_s;
    logic                 pop_fire_s;
    logic                 rd_issue_s;
    logic [2:0]           pending_s;
    logic [1:0]           out_count_n_s;
    logic [DATAWIDTH-1:0] buf0_n_s;
    logic [DATAWIDTH-1:0] buf1_n_s;

    // Handshake and read-issue decisions; reset also blocks push so no write leaks out during reset.
    always_comb begin
        push_ready_s = 1'b0;
        pop_fire_s   = 1'b0;
        pending_s    = 3'd0;
        rd_issue_s   = 1'b0;
        if (!reset && !flush && (mem_count_r != MEM_FULL)) begin
            push_ready_s = 1'b1;
        end else begin
            push_ready_s = 1'b0;
        end
        push_fire_s = push_valid && push_ready_s;
        pop_fire_s  = (out_count_r != 2'd0) && pop_ready;
        // Words already owed to the output buffer after this cycle's pop.
        pending_s   = {1'b0, out_count_r} + {2'b00, rd_inflight_r} - {2'b00, pop_fire_s};
        if (!flush && (mem_count_r != {(ADDRWIDTH+1){1'b0}}) && (pending_s < 3'd2)) begin
            rd_issue_s = 1'b1;
        end else begin
            rd_issue_s = 1'b0;
        end
    end

    // Output buffer next state: head in buf0, second entry in buf1.
    always_comb begin
        buf0_n_s      = buf0_r;
        buf1_n_s      = buf1_r;
        out_count_n_s = out_count_r;
        case ({rd_inflight_r, pop_fire_s})
            2'b10: begin
                if (out_count_r == 2'd0) begin
                    buf0_n_s = mem_doutb;
                end else begin
                    buf1_n_s = mem_doutb;
                end
                out_count_n_s = out_count_r + 2'd1;
            end
            2'b01: begin
                buf0_n_s      = buf1_r;
                out_count_n_s = out_count_r - 2'd1;
            end
            2'b11: begin
                if (out_count_r == 2'd1) begin
                    buf0_n_s = mem_doutb;
                end else begin
                    buf0_n_s = buf1_r;
                    buf1_n_s = mem_doutb;
                end
            end
            default: begin
                out_count_n_s = out_count_r;
            end
        endcase
    end

    // Pointer, count and in-flight tracking; flush wins over every other update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r      <= {ADDRWIDTH{1'b0}};
            rd_ptr_r      <= {ADDRWIDTH{1'b0}};
            mem_count_r   <= {(ADDRWIDTH+1){1'b0}};
            rd_inflight_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r      <= {ADDRWIDTH{1'b0}};
            rd_ptr_r      <= {ADDRWIDTH{1'b0}};
            mem_count_r   <= {(ADDRWIDTH+1){1'b0}};
            rd_inflight_r <= 1'b0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + ADDRWIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + ADDRWIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_fire_s, rd_issue_s})
                2'b10:   mem_count_r <= mem_count_r + (ADDRWIDTH+1)'(1);
                2'b01:   mem_count_r <= mem_count_r - (ADDRWIDTH+1)'(1);
                default: mem_count_r <= mem_count_r;
            endcase
            rd_inflight_r <= rd_issue_s;
        end
    end

    // Output buffer registers; an in-flight read during flush is dropped with the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_count_r <= 2'd0;
            buf0_r      <= {DATAWIDTH{1'b0}};
            buf1_r      <= {DATAWIDTH{1'b0}};
        end else if (flush) begin
            out_count_r <= 2'd0;
            buf0_r      <= buf0_r;
            buf1_r      <= buf1_r;
        end else begin
            out_count_r <= out_count_n_s;
            buf0_r      <= buf0_n_s;
            buf1_r      <= buf1_n_s;
        end
    end

    assign push_ready = push_ready_s;
    assign pop_valid  = (out_count_r != 2'd0);
    assign pop_data   = buf0_r;
    assign fill_level = {1'b0, mem_count_r}
                      + (ADDRWIDTH+2)'(rd_inflight_r)
                      + (ADDRWIDTH+2)'(out_count_r);
    assign mem_ena    = push_fire_s;
    assign mem_wea    = {DATAWIDTH{push_fire_s}};
    assign mem_addra  = wr_ptr_r;
    assign mem_dina   = push_data;
    assign mem_enb    = rd_issue_s;
    assign mem_addrb  = rd_ptr_r;

endmodule

// File: tb/tb_mem_tp_fifo_ctrl.sv
// Self-checking bench for mem_tp_fifo_ctrl (depth 4, 8-bit words) with a queue-based
// reference model, a behavioural two-port memory and directed scenarios.
module tb_mem_tp_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW+1:0] fill_level;
    logic          mem_ena;
    logic [DW-1:0] mem_wea;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dina;
    logic          mem_enb;
    logic [AW-1:0] mem_addrb;
    logic [DW-1:0] mem_doutb = 8'h00;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    mem_tp_fifo_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .fill_level(fill_level),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural two-port memory with one cycle of read latency.
    logic [DW-1:0] tmem [4];
    always @(posedge clk) begin
        if (mem_ena) tmem[mem_addra] <= mem_dina;
        if (mem_enb) mem_doutb <= tmem[mem_addrb];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words sitting in memory, words being read, words in the output buffer.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] iq[$];
    logic [DW-1:0] oq[$];
    int  wr_n = 0;
    int  rd_n = 0;
    bit  e_push_ready, e_pop_valid, e_pop_fire, e_enb, e_ena;
    int  e_fill;

    always @(negedge clk) begin
        e_push_ready = !flush && (mq.size() != 4);
        e_pop_valid  = (oq.size() != 0);
        e_pop_fire   = e_pop_valid && pop_ready;
        e_enb        = !flush && (mq.size() != 0)
                       && ((oq.size() + iq.size() - (e_pop_fire ? 1 : 0)) < 2);
        e_ena        = push_valid && e_push_ready;
        e_fill       = mq.size() + iq.size() + oq.size();
        if (!reset && chk_en) begin
            chk("m_push_ready", push_ready, e_push_ready);
            chk("m_pop_valid", pop_valid, e_pop_valid);
            if (e_pop_valid) chk("m_pop_data", pop_data, oq[0]);
            chk("m_mem_ena", mem_ena, e_ena);
            chk("m_mem_wea", mem_wea, e_ena ? 32'hFF : 32'h0);
            if (e_ena) begin
                chk("m_mem_addra", mem_addra, wr_n);
                chk("m_mem_dina", mem_dina, push_data);
            end
            chk("m_mem_enb", mem_enb, e_enb);
            if (e_enb) chk("m_mem_addrb", mem_addrb, rd_n);
            chk("m_fill_level", fill_level, e_fill);
        end
    end

    always @(posedge clk or posedge reset) begin
        logic [DW-1:0] w;
        if (reset || flush) begin
            mq.delete(); iq.delete(); oq.delete();
            wr_n = 0; rd_n = 0;
        end else begin
            if (e_pop_fire) w = oq.pop_front();
            if (iq.size() != 0) begin
                w = iq.pop_front();
                oq.push_back(w);
            end
            if (e_enb) begin
                w = mq.pop_front();
                iq.push_back(w);
                rd_n = (rd_n + 1) % 4;
            end
            if (e_ena) begin
                mq.push_back(push_data);
                wr_n = (wr_n + 1) % 4;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, k, first, last;
        bit acc, got;
        reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = 8'h00; pop_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_pop_valid", pop_valid, 1'b0);
        chk("reset_fill", fill_level, 0);
        chk("reset_push_ready", push_ready, 1'b1);
        chk("reset_mem_ena", mem_ena, 1'b0);
        chk("reset_mem_enb", mem_enb, 1'b0);

        // Single word: latency push -> pop_valid is 3 cycles.
        tick();
        push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b1;
        @(negedge clk);
        chk("single_ena", mem_ena, 1'b1);
        chk("single_addra", mem_addra, 0);
        tick(); push_valid = 1'b0;
        @(negedge clk);
        chk("single_enb", mem_enb, 1'b1);
        chk("single_addrb", mem_addrb, 0);
        tick(); tick();
        @(negedge clk);
        chk("single_pop_valid", pop_valid, 1'b1);
        chk("single_pop_data", pop_data, 8'hA5);
        tick();
        @(negedge clk);
        chk("single_fill_after", fill_level, 0);

        // Fill: only 6 of 8 offered words fit.
        tick();
        pop_ready = 1'b0; nxt = 1;
        for (int i = 0; i < 12; i++) begin
            push_valid = (nxt <= 8);
            push_data  = nxt[7:0];
            @(negedge clk);
            acc = push_valid && push_ready;
            tick();
            if (acc) nxt++;
        end
        push_valid = 1'b0;
        chk("fill_accepted", nxt - 1, 6);
        @(negedge clk);
        chk("fill_level_full", fill_level, 6);
        chk("fill_push_ready", push_ready, 1'b0);
        tick();
        pop_ready = 1'b1; k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pop_valid) begin
                chk("fill_order", pop_data, k + 1);
                k++;
            end
            tick();
        end
        chk("fill_pop_count", k, 6);
        @(negedge clk);
        chk("fill_empty", fill_level, 0);

        // Streaming: 20 words, one push and one pop per cycle.
        tick();
        pop_ready = 1'b1; k = 0; first = -1; last = -1;
        for (int i = 0; i < 30; i++) begin
            push_valid = (i < 20);
            push_data  = i[7:0];
            @(negedge clk);
            if (push_valid) chk("stream_push_ready", push_ready, 1'b1);
            if (pop_valid) begin
                if (first < 0) first = i;
                last = i;
                chk("stream_order", pop_data, k);
                k++;
            end
            tick();
        end
        push_valid = 1'b0;
        chk("stream_count", k, 20);
        chk("stream_latency", first, 3);
        chk("stream_no_bubble", last - first, 19);

        // Backpressure: pop_ready toggles every cycle.
        k = 0; nxt = 0;
        for (int i = 0; i < 80; i++) begin
            pop_ready  = i[0];
            push_valid = (nxt < 20);
            push_data  = nxt[7:0];
            @(negedge clk);
            acc = push_valid && push_ready;
            if (pop_valid && pop_ready) begin
                chk("bp_order", pop_data, k);
                k++;
            end
            tick();
            if (acc) nxt++;
        end
        push_valid = 1'b0;
        chk("bp_count", k, 20);

        // Flush while a read is in flight.
        pop_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            push_valid = 1'b1;
            push_data  = 8'h31 + j[7:0];
            @(negedge clk);
            if (j == 2) chk("flush_pre_enb", mem_enb, 1'b1);
            tick();
        end
        flush = 1'b1; push_valid = 1'b1; push_data = 8'h99; pop_ready = 1'b1;
        @(negedge clk);
        chk("flush_push_ready", push_ready, 1'b0);
        chk("flush_mem_ena", mem_ena, 1'b0);
        chk("flush_mem_enb", mem_enb, 1'b0);
        tick();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        @(negedge clk);
        chk("flush_pop_valid", pop_valid, 1'b0);
        chk("flush_fill", fill_level, 0);
        tick();
        push_valid = 1'b1; push_data = 8'h77; pop_ready = 1'b1;
        @(negedge clk);
        tick();
        push_valid = 1'b0; got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pop_valid && !got) begin
                chk("flush_after_data", pop_data, 8'h77);
                got = 1'b1;
            end
            tick();
        end
        chk("flush_after_popped", got, 1'b1);

        // Asynchronous reset between clock edges mid-stream.
        pop_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_data  = 8'h50 + i[7:0];
            @(negedge clk);
            tick();
        end
        #2 reset = 1'b1;
        #1;
        chk("areset_pop_valid", pop_valid, 1'b0);
        chk("areset_mem_ena", mem_ena, 1'b0);
        chk("areset_mem_enb", mem_enb, 1'b0);
        chk("areset_fill", fill_level, 0);
        tick();
        reset = 1'b0; push_valid = 1'b0;
        @(negedge clk);
        chk("areset_push_ready", push_ready, 1'b1);
        chk("areset_pop_valid_after", pop_valid, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
